key_sequencer: RTL and testbench
================================

// Module: key_sequencer
// PURPOSE
//  Transmit side of the push-button lock interface: replays a stored combination as
//  timed PB_1/PB_0 press/release pulses, one symbol per press. Long enough hold/gap
//  times let the lock's slow-clock edge detector see each press exactly once.
//  Drives the PB_1/PB_0 inputs of the lock FSM for auto-unlock and bench stimulus.
// PARAMETERS
//  SEQ_LEN      4        symbols per combination (>=1)
//  HOLD_CYCLES  1048576  Clock cycles a button is held pressed per symbol (>=1)
//  GAP_CYCLES   1048576  Clock cycles both buttons released after each press (>=1)
// PORTS
//  Clock      in   1        system clock, all logic on rising edge
//  Reset      in   1        asynchronous, active-low reset
//  Start      in   1        request transmission of Code (sampled when idle)
//  Abort      in   1        cancel transmission in progress
//  Code       in   SEQ_LEN  combination; bit SEQ_LEN-1 sent first; 1=PB_1, 0=PB_0
//  PB_1       out  1        button-1 drive, active-high (pressed)
//  PB_0       out  1        button-0 drive, active-high (pressed)
//  Busy       out  1        high from cycle after accepted Start until return to IDLE
//  Done       out  1        one-cycle pulse after last gap completes (not on Abort)
//  Sym_Index  out  $clog2(SEQ_LEN+1)  index of symbol being sent, 0..SEQ_LEN-1
// BEHAVIOUR
//  - Reset low (async): state IDLE; PB_1=PB_0=0, Busy=0, Done=0, Sym_Index=0,
//    hold/gap counter=0, latched code=0. All outputs registered.
//  - States: IDLE, PRESS, RELEASE, DONE.
//  - IDLE: Start=1 & Abort=0 at edge t -> latch Code, Sym_Index=0, enter PRESS;
//    from cycle t+1 Busy=1 and the button of symbol 0 is 1 (latency 1 cycle).
//  - PRESS: exactly one of PB_1/PB_0 high, per latched bit [SEQ_LEN-1-Sym_Index];
//    held exactly HOLD_CYCLES cycles, then RELEASE. Never both buttons high.
//  - RELEASE: PB_1=PB_0=0 for exactly GAP_CYCLES cycles. Then: if
//    Sym_Index==SEQ_LEN-1 -> DONE, else Sym_Index+1 and PRESS.
//  - DONE: one cycle; Done=1, Busy=1, buttons 0; next cycle IDLE, Busy=0,
//    Sym_Index=0. A Start in the DONE cycle is ignored.
//  - Total Busy length = SEQ_LEN*(HOLD_CYCLES+GAP_CYCLES)+1 cycles.
//  - Start while not IDLE: ignored; Code changes after latch have no effect.
//  - Abort=1 in any non-IDLE state: next cycle IDLE, buttons 0, Busy=0, Done=0,
//    Sym_Index=0. Abort+Start in IDLE same cycle: Abort wins, stay IDLE.
//  - Counter: single down/up counter, width $clog2(max(HOLD,GAP)+1); reloaded on
//    every state entry; no wrap (terminal count ends the phase).
//  - Reset asserted mid-transmission: buttons released immediately (async).
// TESTING (bench uses HOLD_CYCLES=3, GAP_CYCLES=2, SEQ_LEN=4)
//  1 Reset low then high, no Start -> PB_1=PB_0=Busy=Done=0, Sym_Index=0 for 20 cycles.
//  2 Code=4'b1011, Start 1 cycle -> PB_1 3cy, gap 2, PB_0 3cy, gap 2, PB_1 3, gap 2,
//    PB_1 3, gap 2; Done pulses on cycle 21 after Start; Busy high 21 cycles.
//  3 Start again at Sym_Index=1 with Code=4'b0000 -> ignored; output still 1011.
//  4 Abort during 3rd press -> next cycle buttons 0, Busy=0, no Done pulse;
//    new Start then replays full sequence from symbol 0.
//  5 Start and Abort together in IDLE -> stays IDLE, Busy=0.
//  6 Reset low during PRESS -> PB outputs 0 without waiting for clock edge;
//    after release, Start with Code=4'b0101 -> correct full sequence.

Source files
------------

// File: rtl/key_sequencer_if.sv
// ---------------------------------------------------------------------------
// key_sequencer_if
//   Bundles the request side and the button-drive side of the key sequencer.
//   The master (requester / bench) issues start/abort/code and watches the
//   button drives and status; the slave is the sequencer itself.
//
//   start     master->slave  request transmission of code (sampled when idle)
//   abort     master->slave  cancel a transmission in progress
//   code      master->slave  combination, MSB sent first, 1=PB_1, 0=PB_0
//   pb1       slave->master  button-1 drive, high while pressed
//   pb0       slave->master  button-0 drive, high while pressed
//   busy      slave->master  high from the cycle after an accepted start until idle
//   done      slave->master  one-cycle pulse after the final gap (never on abort)
//   symIndex  slave->master  index of the symbol currently being sent
// ---------------------------------------------------------------------------
interface key_sequencer_if #(
  parameter int SEQ_LEN = 4
);
  localparam int IDXW = $clog2(SEQ_LEN + 1);

  logic               start;
  logic               abort;
  logic [SEQ_LEN-1:0] code;
  logic               pb1;
  logic               pb0;
  logic               busy;
  logic               done;
  logic [IDXW-1:0]    symIndex;

  modport master (
    output start, abort, code,
    input  pb1, pb0, busy, done, symIndex
  );

  modport slave (
    input  start, abort, code,
    output pb1, pb0, busy, done, symIndex
  );
endinterface

// File: rtl/key_sequencer.sv
// ---------------------------------------------------------------------------
// key_sequencer
//   Transmit side of the push-button lock interface. Replays a latched
//   combination as timed press/release pulses on PB_1/PB_0, one symbol per
//   press, so that the lock's slow-clock edge detector sees each press once.
//
//   clk_i   system clock, everything on the rising edge
//   rst_ni  asynchronous active-low reset; releases both buttons immediately
//   bus     key_sequencer_if slave: start/abort/code in,
//           pb1/pb0/busy/done/symIndex out (all registered)
// ---------------------------------------------------------------------------
module key_sequencer #(
  parameter int SEQ_LEN     = 4,
  parameter int HOLD_CYCLES = 1048576,
  parameter int GAP_CYCLES  = 1048576
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  key_sequencer_if.slave      bus
);

  localparam int IDXW = $clog2(SEQ_LEN + 1);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE,
    DONE
  } state_t;

  state_t             state_q;
  logic [SEQ_LEN-1:0] code_q;
  logic [IDXW-1:0]    symIdx_q;
  logic [CW-1:0]      cnt_q;
  logic               pb1_q;
  logic               pb0_q;
  logic               busy_q;
  logic               done_q;

  logic [IDXW-1:0]    symIdx_d;
  logic               nextBit_d;

  // Index and button value of the symbol that follows the current one, so
  // the press can start on the very cycle PRESS is entered.
  always_comb begin
    symIdx_d  = symIdx_q + 1'b1;
    nextBit_d = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if ((SEQ_LEN - 1 - i) == int'(symIdx_d)) nextBit_d = code_q[i];
    end
  end

  // Sequencer FSM. The counter counts down from the phase length minus one
  // and the phase ends on the cycle it reads zero, so every phase lasts
  // exactly its programmed number of cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      code_q   <= '0;
      symIdx_q <= '0;
      cnt_q    <= '0;
      pb1_q    <= 1'b0;
      pb0_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q  <= IDLE;
        symIdx_q <= '0;
        cnt_q    <= '0;
        pb1_q    <= 1'b0;
        pb0_q    <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Abort wins over a simultaneous start.
            if (bus.start && !bus.abort) begin
              state_q  <= PRESS;
              code_q   <= bus.code;
              symIdx_q <= '0;
              cnt_q    <= CW'(HOLD_CYCLES - 1);
              pb1_q    <= bus.code[SEQ_LEN-1];
              pb0_q    <= !bus.code[SEQ_LEN-1];
              busy_q   <= 1'b1;
            end
          end
          PRESS: begin
            if (cnt_q == '0) begin
              state_q <= RELEASE;
              cnt_q   <= CW'(GAP_CYCLES - 1);
              pb1_q   <= 1'b0;
              pb0_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RELEASE: begin
            if (cnt_q == '0) begin
              if (int'(symIdx_q) == SEQ_LEN - 1) begin
                state_q <= DONE;
                cnt_q   <= '0;
                done_q  <= 1'b1;
              end else begin
                state_q  <= PRESS;
                symIdx_q <= symIdx_d;
                cnt_q    <= CW'(HOLD_CYCLES - 1);
                pb1_q    <= nextBit_d;
                pb0_q    <= !nextBit_d;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DONE: begin
            // A start seen here is dropped; a new one is only taken from IDLE.
            state_q  <= IDLE;
            symIdx_q <= '0;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pb1      = pb1_q;
  assign bus.pb0      = pb0_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.symIndex = symIdx_q;

endmodule

// File: tb/tb_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_key_sequencer
//   Self-checking bench for key_sequencer with a short hold/gap. The expected
//   per-cycle output stream of a transmission is generated from the
//   combination as a queue and compared cycle by cycle against the DUT.
// ---------------------------------------------------------------------------
module tb_key_sequencer;

  localparam int SEQ_LEN = 4;
  localparam int HOLD    = 3;
  localparam int GAP     = 2;
  localparam int IDXW    = $clog2(SEQ_LEN + 1);

  typedef logic [IDXW+3:0] obs_t;  // {pb1, pb0, busy, done, symIndex}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_sequencer_if #(.SEQ_LEN(SEQ_LEN)) bus ();

  key_sequencer #(
    .SEQ_LEN    (SEQ_LEN),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  obs_t expQ[$];
  obs_t idleVec = '0;

  function automatic obs_t observe();
    return {bus.pb1, bus.pb0, bus.busy, bus.done, bus.symIndex};
  endfunction

  // Reference: each symbol is HOLD cycles with its button down, GAP cycles
  // released, then one done cycle; busy throughout.
  function automatic void buildExpected(input logic [SEQ_LEN-1:0] code);
    logic b;
    expQ.delete();
    for (int s = 0; s < SEQ_LEN; s++) begin
      b = code[SEQ_LEN-1-s];
      for (int c = 0; c < HOLD; c++) expQ.push_back({b, ~b, 1'b1, 1'b0, IDXW'(s)});
      for (int c = 0; c < GAP; c++)  expQ.push_back({2'b00, 1'b1, 1'b0, IDXW'(s)});
    end
    expQ.push_back({2'b00, 1'b1, 1'b1, IDXW'(SEQ_LEN - 1)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset state held for 20 cycles with no request.
  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.code  = '0;
    rst_n     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (observe() !== idleVec)
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, observe(), idleVec);
      else passes++;
    end
  endtask

  // Full transmission; with noisy set, random starts and code changes are
  // thrown at the busy sequencer and must have no effect.
  task automatic test_sequence(input logic [SEQ_LEN-1:0] code, input bit noisy);
    buildExpected(code);
    bus.code  = code;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.code  = SEQ_LEN'($urandom);
      end
      checks++;
      if (observe() !== expQ[i])
        $display("[TB] FAIL sequence code=%b cycle %0d: got %b expected %b", code, i, observe(), expQ[i]);
      else passes++;
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (observe() !== idleVec)
      $display("[TB] FAIL sequence_end code=%b: got %b expected %b", code, observe(), idleVec);
    else passes++;
  endtask

  // Start with code 0000 while sending symbol 1 of 1011 is ignored.
  task automatic test_start_ignored();
    buildExpected(4'b1011);
    bus.code  = 4'b1011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      bus.start = (i == HOLD + GAP);
      if (i == HOLD + GAP) bus.code = 4'b0000;
      checks++;
      if (observe() !== expQ[i])
        $display("[TB] FAIL start_ignored cycle %0d: got %b expected %b", i, observe(), expQ[i]);
      else passes++;
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (observe() !== idleVec)
      $display("[TB] FAIL start_ignored_end: got %b expected %b", observe(), idleVec);
    else passes++;
  endtask

  // Abort during the third press, then a full replay from symbol 0.
  task automatic test_abort();
    logic [SEQ_LEN-1:0] code;
    int abortAt;
    code    = SEQ_LEN'($urandom);
    abortAt = 2 * (HOLD + GAP) + 1;
    buildExpected(code);
    bus.code  = code;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i <= abortAt; i++) begin
      checks++;
      if (observe() !== expQ[i])
        $display("[TB] FAIL abort_pre cycle %0d: got %b expected %b", i, observe(), expQ[i]);
      else passes++;
      if (i == abortAt) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (observe() !== idleVec)
        $display("[TB] FAIL abort_idle cycle %0d: got %b expected %b", i, observe(), idleVec);
      else passes++;
      tick();
    end
    test_sequence(code, 1'b0);
  endtask

  // Start and abort together in IDLE: abort wins.
  task automatic test_start_abort_idle();
    bus.code  = 4'b1111;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (observe() !== idleVec)
        $display("[TB] FAIL start_abort_idle cycle %0d: got %b expected %b", i, observe(), idleVec);
      else passes++;
      tick();
    end
  endtask

  // Reset mid-press drops the buttons before any clock edge.
  task automatic test_reset_mid();
    bus.code  = 4'b1000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (observe() !== {2'b10, 1'b1, 1'b0, IDXW'(0)})
      $display("[TB] FAIL reset_mid_press: got %b expected %b", observe(), {2'b10, 1'b1, 1'b0, IDXW'(0)});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pb1, bus.pb0} !== 2'b00)
      $display("[TB] FAIL reset_mid_async: got %b expected %b", {bus.pb1, bus.pb0}, 2'b00);
    else passes++;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (observe() !== idleVec)
      $display("[TB] FAIL reset_mid_idle: got %b expected %b", observe(), idleVec);
    else passes++;
    test_sequence(4'b0101, 1'b0);
  endtask

  // Start held through the DONE cycle is ignored there, then taken in IDLE.
  task automatic test_back_to_back();
    logic [SEQ_LEN-1:0] code;
    code = SEQ_LEN'($urandom);
    buildExpected(code);
    bus.code  = code;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (observe() !== expQ[i])
        $display("[TB] FAIL back_to_back_first cycle %0d: got %b expected %b", i, observe(), expQ[i]);
      else passes++;
      if (i == expQ.size() - 1) bus.start = 1'b1;
      tick();
    end
    checks++;
    if (observe() !== idleVec)
      $display("[TB] FAIL back_to_back_gap: got %b expected %b", observe(), idleVec);
    else passes++;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (observe() !== expQ[i])
        $display("[TB] FAIL back_to_back_second cycle %0d: got %b expected %b", i, observe(), expQ[i]);
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequence(4'b1011, 1'b0);
    test_start_ignored();
    for (int n = 0; n < 4; n++) test_sequence(SEQ_LEN'($urandom), 1'b1);
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
